// File: rtl/lpc_synth_filter.sv
// All-pole LPC synthesis filter: one time-multiplexed MAC, shadow/active coefficient banks,
// circular output history. Define LPC_SYNTH_SAT_EN to clamp outputs instead of wrapping.
module lpc_synth_filter #(
  parameter int ORDER = 10,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int FRAC  = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DW-1:0]         x,
  input  logic                         coef_we,
  input  logic [$clog2(ORDER+1)-1:0]   coef_addr,
  input  logic signed [CW-1:0]         coef_wdata,
  input  logic                         coef_swap,
  output logic                         swap_pending,
  input  logic                         hist_clr,
  output logic signed [DW-1:0]         y,
  output logic                         vout,
  output logic                         sat
);

  localparam int CAW = $clog2(ORDER + 1);
  localparam int PW  = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam int PRW = DW + CW;
  localparam int AW  = DW + CW + CAW + 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                state_q, state_d;
  logic [CAW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q, rd_q, rd_d, newest;
  logic signed [DW-1:0]  x_q;
  logic signed [AW-1:0]  acc_q, acc_d, res, prod_ext;
  logic signed [PRW-1:0] prod;
  logic signed [DW-1:0]  mul_a;
  logic signed [CW-1:0]  mul_b;
  logic signed [CW-1:0]  shadow_q [ORDER+1];
  logic signed [CW-1:0]  active_q [ORDER+1];
  logic signed [DW-1:0]  hist_q   [ORDER];
  logic signed [DW-1:0]  y_q, y_new;
  logic                  vout_q, swap_pending_q, clr_pend_q;
  logic                  accept, push, commit, do_clr;

  assign in_ready     = (state_q != MAC);
  assign accept       = in_valid && in_ready;
  assign y            = y_q;
  assign vout         = vout_q;
  assign swap_pending = swap_pending_q;

  // The active bank is idle outside MAC, so a pending commit may land in OUT as well as IDLE;
  // with back-to-back samples OUT is the only sample boundary that ever occurs.
  assign commit = (state_q != MAC) && swap_pending_q;
  assign do_clr = (state_q == IDLE) && (hist_clr || clr_pend_q);

  // Most recent history slot; in OUT the current result is being written into ptr_q.
  assign newest = (state_q == OUT) ? ptr_q :
                  (ptr_q == '0) ? PW'(ORDER - 1) : ptr_q - 1'b1;

  assign mul_a    = (cnt_q == '0) ? x_q : hist_q[rd_q];
  assign mul_b    = active_q[cnt_q];
  assign prod     = mul_a * mul_b;
  assign prod_ext = {{(AW-PRW){prod[PRW-1]}}, prod};
  assign res      = acc_q >>> FRAC;

`ifdef LPC_SYNTH_SAT_EN
  localparam logic signed [AW-1:0] YMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic sat_q, sat_new;

  always_comb begin
    sat_new = 1'b0;
    y_new   = res[DW-1:0];
    if (res > YMAX) begin
      y_new   = {1'b0, {(DW-1){1'b1}}};
      sat_new = 1'b1;
    end else if (res < YMIN) begin
      y_new   = {1'b1, {(DW-1){1'b0}}};
      sat_new = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       sat_q <= 1'b0;
    else if (push) sat_q <= sat_new;
  end

  assign sat = sat_q;
`else
  assign y_new = res[DW-1:0];
  assign sat   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MAC;
          cnt_d   = '0;
          acc_d   = '0;
          rd_d    = newest;
        end
      end
      MAC: begin
        if (cnt_q == '0) begin
          acc_d = acc_q + prod_ext;
        end else begin
          acc_d = acc_q - prod_ext;
          rd_d  = (rd_q == '0) ? PW'(ORDER - 1) : rd_q - 1'b1;
        end
        if (cnt_q == CAW'(ORDER)) state_d = OUT;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      OUT: begin
        push = 1'b1;
        if (accept) begin
          state_d = MAC;
          cnt_d   = '0;
          acc_d   = '0;
          rd_d    = newest;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rd_q           <= '0;
      ptr_q          <= '0;
      acc_q          <= '0;
      x_q            <= '0;
      y_q            <= '0;
      vout_q         <= 1'b0;
      swap_pending_q <= 1'b0;
      clr_pend_q     <= 1'b0;
      for (int unsigned i = 0; i < ORDER + 1; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      for (int unsigned i = 0; i < ORDER; i++) hist_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_q           <= rd_d;
      acc_q          <= acc_d;
      vout_q         <= push;
      swap_pending_q <= (swap_pending_q && !commit) || coef_swap;
      clr_pend_q     <= (clr_pend_q || (hist_clr && state_q != IDLE)) && !do_clr;
      if (accept) x_q <= x;
      if (push)   y_q <= y_new;
      if (coef_we && coef_addr <= CAW'(ORDER)) shadow_q[coef_addr] <= coef_wdata;
      if (commit) begin
        for (int unsigned i = 0; i < ORDER + 1; i++) active_q[i] <= shadow_q[i];
      end
      if (do_clr) begin
        for (int unsigned i = 0; i < ORDER; i++) hist_q[i] <= '0;
      end else if (push) begin
        hist_q[ptr_q] <= y_new;
        ptr_q         <= (ptr_q == PW'(ORDER - 1)) ? '0 : ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lpc_synth_filter.sv
// Scoreboard bench for lpc_synth_filter: arithmetic reference model, queued expectations,
// monitor compares y/sat/latency on every vout.
module tb_lpc_synth_filter;
  localparam int ORDER = 10;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int FRAC  = 13;
  localparam int CAW   = $clog2(ORDER + 1);
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (DW - 1));

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, coef_we = 1'b0, coef_swap = 1'b0, hist_clr = 1'b0;
  logic signed [DW-1:0] x = '0;
  logic [CAW-1:0] coef_addr = '0;
  logic signed [CW-1:0] coef_wdata = '0;
  logic in_ready, swap_pending, vout, sat;
  logic signed [DW-1:0] y;

  lpc_synth_filter #(.ORDER(ORDER), .DW(DW), .CW(CW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_swap(coef_swap), .swap_pending(swap_pending), .hist_clr(hist_clr),
    .y(y), .vout(vout), .sat(sat)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int y; bit s; int c; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  // Reference model: coefficient banks as arrays, history newest-first.
  int m_sh[ORDER+1], m_act[ORDER+1], m_h[ORDER];
  bit m_pend;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i <= ORDER; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    for (int i = 0; i < ORDER; i++) m_h[i] = 0;
    m_pend = 0;
  endtask

  task automatic model_step(input int xv, output int yv, output bit sv);
    longint acc, r, w;
    if (m_pend) begin
      for (int i = 0; i <= ORDER; i++) m_act[i] = m_sh[i];
      m_pend = 0;
    end
    acc = longint'(xv) * m_act[0];
    for (int k = 1; k <= ORDER; k++) acc -= longint'(m_act[k]) * m_h[k-1];
    r  = acc >>> FRAC;
    sv = 0;
`ifdef LPC_SYNTH_SAT_EN
    if (r > MAXV)      begin yv = int'(MAXV); sv = 1; end
    else if (r < MINV) begin yv = int'(MINV); sv = 1; end
    else               yv = int'(r);
`else
    w = r & ((longint'(1) << DW) - 1);
    if (w > MAXV) w -= (longint'(1) << DW);
    yv = int'(w);
`endif
    for (int k = ORDER - 1; k > 0; k--) m_h[k] = m_h[k-1];
    m_h[0] = yv;
  endtask

  always @(negedge clk) begin
    if (!rst && vout === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_vout: got vout=1 y=%0d expected no output (cycle %0d)", y, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("y", longint'(y), mon_e.y);
        chk("sat", longint'(sat), mon_e.s);
        chk("latency", cyc, mon_e.c);
      end
    end
  end

  // All driver tasks start and end on a negedge.
  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin ok = 1; return; end
      @(negedge clk);
    end
    fail_now("in_ready_wait");
  endtask

  task automatic send(input int xv);
    bit ok;
    int yv;
    bit sv;
    wait_ready(ok);
    if (!ok) return;
    in_valid = 1'b1;
    x = DW'(xv);
    model_step(xv, yv, sv);
    q.push_back('{yv, sv, cyc + 1 + ORDER + 2});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wr_coef(input int addr, input int val);
    coef_we = 1'b1;
    coef_addr = CAW'(addr);
    coef_wdata = CW'(val);
    if (addr <= ORDER) m_sh[addr] = val;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic swap_pulse();
    coef_swap = 1'b1;
    m_pend = 1;
    @(negedge clk);
    coef_swap = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0) return;
      @(negedge clk);
    end
    fail_now("drain");
    q.delete();
  endtask

  task automatic clr_hist();
    drain();
    hist_clr = 1'b1;
    for (int i = 0; i < ORDER; i++) m_h[i] = 0;
    @(negedge clk);
    hist_clr = 1'b0;
  endtask

  function automatic int rnd_x();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic b2b(input int n);
    int got = 0, last = -1, xv, yv;
    bit sv, acc;
    xv = rnd_x();
    in_valid = 1'b1;
    x = DW'(xv);
    for (int i = 0; i < n * (ORDER + 2) + 50 && got < n; i++) begin
      acc = 0;
      if (in_ready) begin
        model_step(xv, yv, sv);
        q.push_back('{yv, sv, cyc + 1 + ORDER + 2});
        if (last >= 0) chk("b2b_spacing", cyc + 1 - last, ORDER + 2);
        last = cyc + 1;
        got++;
        acc = 1;
      end
      @(negedge clk);
      if (acc) begin xv = rnd_x(); x = DW'(xv); end
    end
    in_valid = 1'b0;
    if (got < n) fail_now("b2b_accepts");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_y", longint'(y), 0);
    chk("rst_vout", longint'(vout), 0);
    chk("rst_sat", longint'(sat), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_swap_pending", longint'(swap_pending), 0);

    // Impulse response: 8192, 4096, 2048, 1024, 512.
    wr_coef(0, 8192);
    wr_coef(1, -4096);
    swap_pulse();
    repeat (2) @(negedge clk);
    send(8192);
    repeat (4) send(0);
    drain();

    b2b(5);
    drain();

    // Swap requested mid-MAC: sample n keeps the old bank, n+1 uses A0=4096.
    send(8192);
    wr_coef(0, 4096);
    wr_coef(1, 0);
    swap_pulse();
    chk("swap_pending_set", longint'(swap_pending), 1);
    drain();
    send(8192);
    chk("swap_pending_clr", longint'(swap_pending), 0);
    drain();

    // Decaying response, then history clear followed by silence.
    wr_coef(0, 8192);
    wr_coef(1, -4096);
    swap_pulse();
    repeat (2) @(negedge clk);
    send(8192);
    send(0);
    send(0);
    clr_hist();
    send(0);
    drain();

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) clr_hist();
      send(rnd_x());
      if ($urandom_range(0, 3) == 0) begin
        wr_coef(int'($urandom_range(0, 15)), int'($urandom_range(0, 16000)) - 8000);
        wr_coef(int'($urandom_range(0, 15)), int'($urandom_range(0, 16000)) - 8000);
        swap_pulse();
      end
    end
    drain();

    // Reset in the middle of a computation, with a swap pending.
    begin
      bit ok;
      wait_ready(ok);
      in_valid = 1'b1;
      x = DW'(1234);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      coef_swap = 1'b1;
      @(negedge clk);
      coef_swap = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("midrst_y", longint'(y), 0);
      chk("midrst_vout", longint'(vout), 0);
      chk("midrst_in_ready", longint'(in_ready), 1);
      chk("midrst_swap_pending", longint'(swap_pending), 0);
      repeat (20) @(negedge clk);
    end

    // Overflow: gain 2.0 on a full-scale input.
    wr_coef(0, 16384);
    for (int k = 1; k <= ORDER; k++) wr_coef(k, 0);
    swap_pulse();
    repeat (2) @(negedge clk);
    send(32767);
    drain();

    if (q.size() != 0) fail_now("final_queue");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
